alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Operand capture/conditioning stage directly upstream of the ALU adder chain
//  (half_adder/full-adder ripple). Accepts {a,b,op} via valid/ready, buffers up to
//  DEPTH transactions, and presents conditioned operands (b inverted + carry-in for
//  subtract) to the adder datapath via valid/ready. Decouples the ALU from the
//  operand source.
// PARAMETERS
//  WIDTH  4  operand width, bits
//  OPW    3  opcode width, bits
//  DEPTH  2  buffer entries; power of 2, >=2
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      upstream transaction valid
//  in_ready   out  1      stage can accept this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   OPW    opcode (3'b000 ADD, 3'b001 SUB, others pass-through)
//  out_valid  out  1      conditioned operands valid
//  out_ready  in   1      ALU accepts this cycle
//  out_a      out  WIDTH  operand A, unmodified
//  out_b      out  WIDTH  B, or ~B when op==SUB
//  out_cin    out  1      1 when op==SUB, else 0
//  out_op     out  OPW    opcode, unmodified
// BEHAVIOUR
//  - Clock/reset: one clock clk; rst synchronous, active-high, sampled on rising edge.
//  - Reset: count=0, wr_ptr=rd_ptr=0, out_valid=0, out_a/out_b/out_op=0, out_cin=0.
//    in_ready=1 from the first cycle after rst deasserts. Reset mid-transfer discards
//    all buffered entries; no partial output.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count < DEPTH); depends only on registered state, never on out_ready.
//  - out_valid = (count != 0). Outputs are driven from the head entry and stay stable
//    while out_valid=1 and out_ready=0.
//  - Conditioning is applied at push time and stored: SUB -> stored b=~in_b, cin=1;
//    all other ops -> b=in_b, cin=0.
//  - Latency: accept at edge N -> out_valid=1 after edge N (next cycle); no
//    combinational in->out path.
//  - Throughput: 1 transaction/cycle while push and pop overlap.
//  - Simultaneous push+pop: count unchanged; both pointers advance.
//  - Full (count==DEPTH): in_ready=0; no push even if pop occurs the same cycle.
//  - Empty: pop is impossible (out_valid=0); out_ready is ignored.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  - Data order is strictly FIFO. No transaction is dropped or duplicated.
// CONFIGURATION
//  ALU_STAGE_BYPASS_EN defined: when count==0 and in_valid=1, the conditioned input
//    drives out_* combinationally with out_valid=1 (zero latency). If out_ready=1 in
//    that cycle, the transaction completes without being stored; otherwise it is
//    pushed normally. in_ready is unchanged (still count<DEPTH).
//  Not defined: no bypass; minimum latency is 1 cycle as stated above.
// TESTING
//  1 Reset: hold rst 2 cycles mid-traffic with 2 entries stored -> out_valid=0,
//    out_*=0, in_ready=1 on the cycle after release.
//  2 Single ADD: a=4'h3, b=4'h5, op=000, out_ready=1 -> next cycle out_a=3, out_b=5,
//    out_cin=0, out_valid for exactly 1 cycle.
//  3 SUB conditioning: a=4'h9, b=4'h4, op=001 -> out_b=4'hB, out_cin=1; the
//    downstream sum a+out_b+cin yields 4'h5.
//  4 Backpressure: out_ready=0, offer 3 transactions -> 2 accepted, in_ready=0 after
//    the 2nd; raise out_ready -> outputs appear in order, then the 3rd is accepted.
//  5 Streaming: in_valid=out_ready=1 for 16 cycles with random ops -> 16 outputs in
//    order, 1/cycle after the first, count stays 1; ptr wrap covered.
//  6 Bypass (ALU_STAGE_BYPASS_EN): empty stage, in_valid=out_ready=1 -> out_valid
//    the same cycle and count stays 0; without the macro, out_valid rises next cycle.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand capture/conditioning FIFO ahead of the ALU adder; optional zero-latency path under ALU_STAGE_BYPASS_EN
module alu_operand_stage #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin,
    output logic [OPW-1:0]   out_op
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PTRW + 1;
    localparam logic [OPW-1:0]  OP_SUB   = OPW'(1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [WIDTH-1:0] a_mem_q   [DEPTH];
    logic [WIDTH-1:0] b_mem_q   [DEPTH];
    logic             cin_mem_q [DEPTH];
    logic [OPW-1:0]   op_mem_q  [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;

    logic [WIDTH-1:0] cond_b;
    logic             cond_cin;
    logic             empty;
    logic             bypass_act;
    logic             push;
    logic             pop;

    // Subtract is turned into A + ~B + 1 before the operands are stored
    assign cond_cin = (in_op == OP_SUB);
    assign cond_b   = cond_cin ? ~in_b : in_b;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL_CNT);

`ifdef ALU_STAGE_BYPASS_EN
    assign bypass_act = empty & in_valid;
`else
    assign bypass_act = 1'b0;
`endif

    // A bypassed transaction taken by the ALU in the same cycle is never stored
    assign push      = in_valid & in_ready & ~(bypass_act & out_ready);
    assign pop       = ~empty & out_ready;
    assign out_valid = ~empty | bypass_act;

    // Present the head entry; zeros when nothing is buffered and no bypass
    always_comb begin
        out_a   = '0;
        out_b   = '0;
        out_cin = 1'b0;
        out_op  = '0;
        if (!empty) begin
            out_a   = a_mem_q[rd_ptr_q];
            out_b   = b_mem_q[rd_ptr_q];
            out_cin = cin_mem_q[rd_ptr_q];
            out_op  = op_mem_q[rd_ptr_q];
        end else if (bypass_act) begin
            out_a   = in_a;
            out_b   = cond_b;
            out_cin = cond_cin;
            out_op  = in_op;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only visible while counted, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem_q[wr_ptr_q]   <= in_a;
            b_mem_q[wr_ptr_q]   <= cond_b;
            cin_mem_q[wr_ptr_q] <= cond_cin;
            op_mem_q[wr_ptr_q]  <= in_op;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
module tb_alu_operand_stage;

    localparam int WIDTH = 4;
    localparam int OPW   = 3;
    localparam int DEPTH = 2;
    localparam int EW    = 2 * WIDTH + 1 + OPW;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_cin;
    logic [OPW-1:0]   out_op;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic last_push;
    logic last_pop;
    logic [EW-1:0] sb [$];

    alu_operand_stage #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_cin   (out_cin),
        .out_op    (out_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [OPW-1:0] op);
        logic sub;
        sub = (op == 3'b001);
        return {a, (sub ? ~b : b), sub, op};
    endfunction

    // Inputs are set before calling; handshakes are judged at the falling edge
    task automatic cycle();
        logic [EW-1:0] exp;
        @(negedge clk);
        last_push = 1'b0;
        last_pop  = 1'b0;
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(model(in_a, in_b, in_op));
                last_push = 1'b1;
            end
            if (out_valid && out_ready) begin
                last_pop = 1'b1;
                pops++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("sb_data", 32'({out_a, out_b, out_cin, out_op}), 32'(exp));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_data"}, 32'({out_a, out_b, out_cin, out_op}), 32'd0);
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        check_idle("reset");

        // Single ADD with a ready consumer
        out_ready = 1'b1;
        offer(4'h3, 4'h5, 3'b000);
`ifdef ALU_STAGE_BYPASS_EN
        check("add_bypass_valid", 32'(out_valid), 32'd1);
        cycle();
        in_valid = 1'b0;
        check("add_after_bypass", 32'(out_valid), 32'd0);
`else
        check("add_no_early", 32'(out_valid), 32'd0);
        cycle();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_a", 32'(out_a), 32'h3);
        check("add_b", 32'(out_b), 32'h5);
        check("add_cin", 32'(out_cin), 32'd0);
        cycle();
        check("add_one_cycle", 32'(out_valid), 32'd0);
`endif

        // SUB conditioning held under backpressure so it can be inspected
        out_ready = 1'b0;
        offer(4'h9, 4'h4, 3'b001);
        cycle();
        in_valid = 1'b0;
        check("sub_b", 32'(out_b), 32'hB);
        check("sub_cin", 32'(out_cin), 32'd1);
        check("sub_sum", 32'(4'(out_a + out_b + 4'(out_cin))), 32'h5);
        out_ready = 1'b1;
        cycle();
        check("sub_drained", 32'(out_valid), 32'd0);

        // Backpressure: three offers, only two fit
        out_ready = 1'b0;
        offer(4'h1, 4'h2, 3'b000);
        cycle();
        offer(4'h7, 4'h3, 3'b001);
        cycle();
        check("bp_full", 32'(in_ready), 32'd0);
        offer(4'hC, 4'hA, 3'b101);
        cycle();
        check("bp_third_held", 32'(last_push), 32'd0);
        out_ready = 1'b1;
        guard = 0;
        while (in_valid && guard < 10) begin
            cycle();
            if (last_push) in_valid = 1'b0;
            guard++;
        end
        check("bp_third_accepted", 32'(in_valid), 32'd0);
        guard = 0;
        while (out_valid && guard < 10) begin
            cycle();
            guard++;
        end
        check("bp_drain", 32'(sb.size()), 32'd0);

        // Streaming: one in, one out every cycle
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            offer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            cycle();
            if (!in_ready) check("stream_ready", 32'(in_ready), 32'd1);
`ifndef ALU_STAGE_BYPASS_EN
            if (!out_valid) check("stream_valid", 32'(out_valid), 32'd1);
`endif
        end
        in_valid = 1'b0;
`ifdef ALU_STAGE_BYPASS_EN
        check("stream_pops", 32'(pops), 32'd16);
`else
        check("stream_pops", 32'(pops), 32'd15);
`endif
        cycle();
        check("stream_empty", 32'(sb.size()), 32'd0);

        // Empty-stage latency with a ready consumer
        offer(4'h6, 4'h2, 3'b001);
`ifdef ALU_STAGE_BYPASS_EN
        check("byp_same_cycle", 32'(out_valid), 32'd1);
        cycle();
        in_valid = 1'b0;
        check("byp_not_stored", 32'(out_valid), 32'd0);
`else
        check("nobyp_same_cycle", 32'(out_valid), 32'd0);
        cycle();
        in_valid = 1'b0;
        check("nobyp_next_cycle", 32'(out_valid), 32'd1);
        cycle();
`endif

        // Reset mid-traffic with two entries stored
        out_ready = 1'b0;
        offer(4'hE, 4'h1, 3'b010);
        cycle();
        offer(4'hD, 4'h2, 3'b001);
        cycle();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_idle("mid_rst");
        out_ready = 1'b1;
        cycle();
        check("post_rst_quiet", 32'(last_pop), 32'd0);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
